// File: rtl/mem_load_return_pkg.sv
// Shared encodings for the memory pipeline: memory-op and access-size codes,
// FSM states of the load-return block, and the default ROM/RAM address split.
package mem_load_return_pkg;

    typedef enum logic [1:0] {
        MEMOP_NONE  = 2'b00,
        MEMOP_LOADS = 2'b01,
        MEMOP_LOADU = 2'b10,
        MEMOP_STORE = 2'b11
    } memop_e;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } memsize_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } load_state_e;

    localparam logic [31:0] ROM_LIMIT_DEFAULT = 32'h0000_FFFF;

    function automatic logic is_load(input logic [1:0] op);
        return (op == MEMOP_LOADS) || (op == MEMOP_LOADU);
    endfunction

endpackage

// File: rtl/mem_load_return_align.sv
// Combinational little-endian load aligner: picks byte/half/word out of a BRAM
// word by byte offset, sign- or zero-extends, and flags misaligned accesses.
module load_align
    import mem_load_return_pkg::*;
(
    input  logic [31:0] dout,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        data     = '0;
        misalign = 1'b0;

        case (off)
            2'd0:    byte_sel = dout[7:0];
            2'd1:    byte_sel = dout[15:8];
            2'd2:    byte_sel = dout[23:16];
            default: byte_sel = dout[31:24];
        endcase
        half_sel = off[1] ? dout[31:16] : dout[15:0];

        case (memsize_e'(size))
            SZ_B: data = sign_ext ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
            SZ_H: begin
                if (off[0]) misalign = 1'b1;
                else        data = sign_ext ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
            end
            // Reserved size code behaves as a word access.
            default: begin
                if (off != 2'b00) misalign = 1'b1;
                else              data = dout;
            end
        endcase
    end

endmodule

// File: rtl/mem_load_return.sv
// Load-return stage: accepts loads from the memory stage, waits out BRAM read
// latency, aligns the selected ROM/RAM word and hands the result to writeback.
module mem_load_return
    import mem_load_return_pkg::*;
#(
    parameter logic [31:0] ROM_LIMIT    = ROM_LIMIT_DEFAULT,
    parameter int          BRAM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [1:0]  memOp,
    input  logic [1:0]  memSize,
    input  logic [31:0] romDout,
    input  logic [31:0] ramDout,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic        wb_misalign
);

    localparam logic [1:0] WAIT_INIT = 2'(BRAM_LATENCY - 1);

    load_state_e state_q, state_d;
    logic [1:0]  cnt_q;
    logic [1:0]  off_q;
    memop_e      op_q;
    memsize_e    size_q;
    logic        src_ram_q;

    logic        load_accept;
    logic        xfer;
    logic        sample;
    logic [31:0] align_data;
    logic        align_mis;

    assign load_accept = req_valid & req_ready & is_load(memOp);
    assign xfer        = wb_valid & wb_ready;
    assign sample      = (state_q == ST_WAIT) && (cnt_q == 2'd0);

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (load_accept) state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == 2'd0) state_d = ST_DONE;
            ST_DONE: if (xfer) state_d = load_accept ? ST_WAIT : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Gating with rst keeps "accept" false in a reset cycle, so rst always wins.
    always_comb begin
        req_ready = 1'b0;
        wb_valid  = 1'b0;
        case (state_q)
            ST_IDLE: req_ready = ~rst;
            ST_DONE: begin
                req_ready = wb_ready & ~rst;
                wb_valid  = 1'b1;
            end
            default: ;
        endcase
    end

    load_align u_align (
        .dout     (src_ram_q ? ramDout : romDout),
        .off      (off_q),
        .size     (size_q),
        .sign_ext (op_q == MEMOP_LOADS),
        .data     (align_data),
        .misalign (align_mis)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            off_q       <= '0;
            op_q        <= MEMOP_NONE;
            size_q      <= SZ_B;
            src_ram_q   <= 1'b0;
            wb_data     <= '0;
            wb_misalign <= 1'b0;
        end else begin
            if (load_accept) begin
                off_q     <= addr[1:0];
                op_q      <= memop_e'(memOp);
                size_q    <= memsize_e'(memSize);
                src_ram_q <= (addr > ROM_LIMIT);
                cnt_q     <= WAIT_INIT;
            end else if (state_q == ST_WAIT && cnt_q != 2'd0) begin
                cnt_q <= cnt_q - 2'd1;
            end
            if (sample) begin
                wb_data     <= align_data;
                wb_misalign <= align_mis;
            end
        end
    end

endmodule
